// File: rtl/ula_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ula_arbiter_pkg : widths, opcodes and request record for ula_arbiter  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package ula_arbiter_pkg;

   localparam int BITS     = 8;
   localparam int OP       = 8;
   localparam int ULA_REQS = 2;

   typedef enum logic [OP-1:0] {
      ULA_NOT   = 8'h00,
      ULA_ADD   = 8'h01,
      ULA_SUB   = 8'h02,
      ULA_AND   = 8'h03,
      ULA_OR    = 8'h04,
      ULA_XOR   = 8'h05,
      ULA_PASSA = 8'h06
   } ula_op_e;

   typedef struct packed {
      logic [BITS-1:0] a;
      logic [BITS-1:0] b;
      logic [OP-1:0]   op;
   } ula_req_t;

endpackage
`default_nettype wire

// File: rtl/ula_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ula_arbiter_if : request/response channels of both ula requesters     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface ula_arbiter_if;
   import ula_arbiter_pkg::*;

   logic            req0_valid_in;
   logic            req0_ready_out;
   logic [BITS-1:0] req0_a_in;
   logic [BITS-1:0] req0_b_in;
   logic [OP-1:0]   req0_op_in;

   logic            req1_valid_in;
   logic            req1_ready_out;
   logic [BITS-1:0] req1_a_in;
   logic [BITS-1:0] req1_b_in;
   logic [OP-1:0]   req1_op_in;

   logic            rsp0_valid_out;
   logic            rsp0_ready_in;
   logic            rsp1_valid_out;
   logic            rsp1_ready_in;
   logic [BITS-1:0] result_out;

   modport slave (
      input  req0_valid_in, req0_a_in, req0_b_in, req0_op_in,
      input  req1_valid_in, req1_a_in, req1_b_in, req1_op_in,
      input  rsp0_ready_in, rsp1_ready_in,
      output req0_ready_out, req1_ready_out,
      output rsp0_valid_out, rsp1_valid_out, result_out
   );

   modport master (
      output req0_valid_in, req0_a_in, req0_b_in, req0_op_in,
      output req1_valid_in, req1_a_in, req1_b_in, req1_op_in,
      output rsp0_ready_in, rsp1_ready_in,
      input  req0_ready_out, req1_ready_out,
      input  rsp0_valid_out, rsp1_valid_out, result_out
   );

endinterface
`default_nettype wire

// File: rtl/ula_arbiter_ula.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ula : purely combinational logic/arithmetic unit                      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module ula
   import ula_arbiter_pkg::*;
(
   input  logic [BITS-1:0] a_in,
   input  logic [BITS-1:0] b_in,
   input  logic [OP-1:0]   op_in,
   output logic [BITS-1:0] result_out
);

   always_comb begin
      result_out = '0;
      case (op_in)
         ULA_NOT:   result_out = ~b_in;
         ULA_ADD:   result_out = a_in + b_in;
         ULA_SUB:   result_out = a_in - b_in;
         ULA_AND:   result_out = a_in & b_in;
         ULA_OR:    result_out = a_in | b_in;
         ULA_XOR:   result_out = a_in ^ b_in;
         ULA_PASSA: result_out = a_in;
         default:   result_out = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ula_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ula_arbiter : round-robin sharing of one ula between two requesters   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module ula_arbiter
   import ula_arbiter_pkg::*;
(
   input  logic          clk_in,
   input  logic          rst_in,
   ula_arbiter_if.slave  bus
);

   logic            pending_q, pending_d;
   logic            owner_q,   owner_d;
   logic            last_q,    last_d;
   logic [BITS-1:0] result_q,  result_d;

   logic            consume;
   logic            free;
   logic            grant;
   logic            accept;
   logic [BITS-1:0] mux_a;
   logic [BITS-1:0] mux_b;
   logic [OP-1:0]   mux_op;
   logic [BITS-1:0] ula_result;

   // A result consumed this cycle frees the slot for an immediate re-issue.
   always_comb begin
      consume = pending_q && (owner_q ? bus.rsp1_ready_in : bus.rsp0_ready_in);
      free    = !pending_q || consume;
      if (bus.req0_valid_in && bus.req1_valid_in)
         grant = !last_q;
      else
         grant = bus.req1_valid_in;
      accept  = free && (bus.req0_valid_in || bus.req1_valid_in) && !rst_in;
   end

   assign bus.req0_ready_out = accept && !grant;
   assign bus.req1_ready_out = accept &&  grant;

   always_comb begin
      mux_a  = grant ? bus.req1_a_in  : bus.req0_a_in;
      mux_b  = grant ? bus.req1_b_in  : bus.req0_b_in;
      mux_op = grant ? bus.req1_op_in : bus.req0_op_in;
   end

   ula u_ula (
      .a_in       (mux_a),
      .b_in       (mux_b),
      .op_in      (mux_op),
      .result_out (ula_result)
   );

   always_comb begin
      pending_d = pending_q;
      owner_d   = owner_q;
      last_d    = last_q;
      result_d  = result_q;
      if (accept) begin
         pending_d = 1'b1;
         owner_d   = grant;
         last_d    = grant;
         result_d  = ula_result;
      end else if (consume) begin
         pending_d = 1'b0;
      end
   end

   // last resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pending_q <= 1'b0;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         result_q  <= '0;
      end else begin
         pending_q <= pending_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         result_q  <= result_d;
      end
   end

   assign bus.rsp0_valid_out = pending_q && !owner_q;
   assign bus.rsp1_valid_out = pending_q &&  owner_q;
   assign bus.result_out     = result_q;

endmodule
`default_nettype wire
